// File: rtl/gold_tx_scheduler.sv
// gold_tx_scheduler: frame-granular round-robin arbiter in front of one Gold-code transmitter.
// Locks the grant for a whole frame, caps frame length and spaces frames with a guard gap.
module gold_tx_scheduler #(
    parameter  int NUM_SRC      = 4,
    parameter  int DWIDTH       = 5,
    parameter  int MAX_LEN      = 64,
    parameter  int GUARD_CYCLES = 8,
    localparam int IW           = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      s_axis_aclk,
    input  logic                      areset,
    input  logic [NUM_SRC-1:0]        s_axis_tvalid,
    output logic [NUM_SRC-1:0]        s_axis_tready,
    input  logic [NUM_SRC*DWIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]        s_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [DWIDTH-1:0]         m_axis_tdata,
    output logic                      m_axis_tlast,
    output logic                      strobe,
    output logic [IW-1:0]             grant_id,
    output logic                      busy,
    output logic                      trunc_pulse
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [LW-1:0] LEN_LAST   = LW'(MAX_LEN - 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        SEND  = 2'd2,
        GUARD = 2'd3
    } state_t;

    state_t        state;
    logic [IW-1:0] last_grant;
    logic [LW-1:0] len_cnt;
    logic [GW-1:0] guard_cnt;
    logic [IW-1:0] arb_sel;
    logic [IW-1:0] cand;
    logic          arb_found;
    logic          src_last;
    logic          xfer;

    // Round-robin scan starting just after the previous winner, wrapping at NUM_SRC.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = IW'((int'(last_grant) + k) % NUM_SRC);
            if (!arb_found && s_axis_tvalid[cand]) begin
                arb_found = 1'b1;
                arb_sel   = cand;
            end
        end
    end

    // Zero-latency pass-through of the granted source while the frame is locked.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        trunc_pulse   = 1'b0;
        src_last      = 1'b0;
        xfer          = 1'b0;
        if (state == SEND) begin
            src_last                = s_axis_tlast[grant_id];
            m_axis_tvalid           = s_axis_tvalid[grant_id];
            m_axis_tdata            = s_axis_tdata[int'(grant_id)*DWIDTH +: DWIDTH];
            m_axis_tlast            = src_last | (len_cnt == LEN_LAST);
            s_axis_tready[grant_id] = m_axis_tready;
            xfer                    = m_axis_tvalid & m_axis_tready;
            trunc_pulse             = xfer & m_axis_tlast & ~src_last;
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (areset) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= IW'(NUM_SRC - 1);
            len_cnt    <= '0;
            guard_cnt  <= '0;
            strobe     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|s_axis_tvalid) begin
                        state <= ARB;
                        busy  <= 1'b1;
                    end
                end
                ARB: begin
                    if (arb_found) begin
                        state      <= SEND;
                        grant_id   <= arb_sel;
                        last_grant <= arb_sel;
                        len_cnt    <= '0;
                        strobe     <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (m_axis_tlast) begin
                            len_cnt <= '0;
                            strobe  <= 1'b0;
                            if (GUARD_CYCLES > 0) begin
                                state     <= GUARD;
                                guard_cnt <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            len_cnt <= len_cnt + 1'b1;
                        end
                    end
                end
                GUARD: begin
                    if (guard_cnt == GUARD_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        guard_cnt <= guard_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    strobe <= 1'b0;
                end
            endcase
        end
    end

endmodule
